fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv_pkg.sv | 21 ++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP, base opcodes and reset vectors.
package rv_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_JALR         = 7'b1100111;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RESET/RUN/WAIT fetch FSM, next-PC mux and IF/EX register; one instruction per accepted fetch.
// Stall holds everything and drops imem_req; MISALIGN_TRAP_EN routes misaligned redirects to TRAP_VEC.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_ex_valid,
    output logic [31:0] if_ex_pc,
    output logic [31:0] if_ex_instr,
    output logic        misaligned_trap
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_valid;
    logic [31:0]  r_ex_pc;
    logic [31:0]  r_instr;

    logic         w_req;
    logic         w_accept;
    logic         w_redirect;
    logic         w_misaligned;
    logic [31:0]  w_target;

    assign w_req      = (r_state != ST_RESET) && !stall;
    assign w_accept   = w_req && imem_ready;
    assign w_redirect = branch_taken && r_valid && !stall;

`ifdef MISALIGN_TRAP_EN
    logic r_trap;

    assign w_misaligned = |branch_target[1:0];
    assign w_target     = w_misaligned ? TRAP_VEC : branch_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_redirect && w_misaligned;
        end
    end

    assign misaligned_trap = r_trap;
`else
    // Low bits are cleared rather than trapped; masking keeps every input bit in use.
    assign w_misaligned    = 1'b0;
    assign w_target        = branch_target & ~32'h0000_0003;
    assign misaligned_trap = w_misaligned;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_ex_pc <= 32'h0000_0000;
            r_instr <= NOP;
        end else if (!stall) begin
            if (w_redirect) begin
                // Any fetch accepted this cycle is on the wrong path and is dropped.
                r_state <= ST_RUN;
                r_pc    <= w_target;
                r_valid <= 1'b0;
                r_instr <= NOP;
            end else if (w_accept) begin
                r_state <= ST_RUN;
                r_pc    <= pc_next_seq(r_pc);
                r_valid <= 1'b1;
                r_ex_pc <= r_pc;
                r_instr <= imem_rdata;
            end else begin
                r_state <= (r_state == ST_RESET) ? ST_RUN : ST_WAIT;
                r_valid <= 1'b0;
                r_instr <= NOP;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_ex_valid = r_valid;
    assign if_ex_pc    = r_ex_pc;
    assign if_ex_instr = r_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/EX contents queued at issue, popped by an independent monitor.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_ex_valid;
    logic [31:0] if_ex_pc;
    logic [31:0] if_ex_instr;
    logic        misaligned_trap;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic        prev_stall = 1'b0;

    logic [31:0] redir_pc;
    logic        redir_trap;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_ex_valid    (if_ex_valid),
        .if_ex_pc       (if_ex_pc),
        .if_ex_instr    (if_ex_instr),
        .misaligned_trap(misaligned_trap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    // A new IF/EX entry appears only when the previous cycle was not stalled.
    always @(negedge clk) begin
        logic [63:0] e;
        if (if_ex_valid && !prev_stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ifex: got pc %h with empty queue", if_ex_pc);
            end else begin
                e = exp_q.pop_front();
                chk("ifex_pc", if_ex_pc, e[63:32]);
                chk("ifex_instr", if_ex_instr, e[31:0]);
            end
        end
        prev_stall = stall;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MISALIGN_TRAP_EN
        redir_pc   = 32'h0000_0100;
        redir_trap = 1'b1;
`else
        redir_pc   = 32'h0000_0040;
        redir_trap = 1'b0;
`endif
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b1;
        step(); step(); sample();
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_ex_valid}, 32'd0);
        chk("rst_pc",    if_ex_pc, 32'h0);
        chk("rst_instr", if_ex_instr, 32'h0000_0013);
        chk("rst_trap",  {31'b0, misaligned_trap}, 32'd0);

        step(); rst = 1'b0; sample();                       // c0: RESET state
        chk("c0_req",  {31'b0, imem_req}, 32'd0);
        chk("c0_addr", imem_addr, 32'h0);
        step(); sample();                                   // c1
        chk("c1_req",  {31'b0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0); push(32'h0);
        step(); sample();                                   // c2
        chk("c2_addr", imem_addr, 32'h4); push(32'h4);
        step(); branch_taken = 1'b1; branch_target = 32'h40; sample(); // c3: IF/EX holds 4
        chk("c3_addr", imem_addr, 32'h8);
        step(); branch_taken = 1'b0; sample();              // c4: bubble
        chk("c4_addr",  imem_addr, 32'h40);
        chk("c4_valid", {31'b0, if_ex_valid}, 32'd0);
        push(32'h40);
        step(); sample();                                   // c5
        chk("c5_addr", imem_addr, 32'h44); push(32'h44);

        step(); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h8; sample(); // c6
        chk("c6_req",  {31'b0, imem_req}, 32'd0);
        chk("c6_addr", imem_addr, 32'h48);
        step(); sample();                                   // c7: still stalled
        chk("c7_req",   {31'b0, imem_req}, 32'd0);
        chk("c7_addr",  imem_addr, 32'h48);
        chk("c7_pc",    if_ex_pc, 32'h44);
        chk("c7_valid", {31'b0, if_ex_valid}, 32'd1);
        step(); stall = 1'b0; sample();                     // c8: redirect taken
        chk("c8_req",  {31'b0, imem_req}, 32'd1);
        chk("c8_addr", imem_addr, 32'h48);

        step(); branch_taken = 1'b0; imem_ready = 1'b0; sample(); // c9
        chk("c9_addr",  imem_addr, 32'h8);
        chk("c9_valid", {31'b0, if_ex_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin                   // c10, c11: WAIT
            step(); sample();
            chk("wait_req",   {31'b0, imem_req}, 32'd1);
            chk("wait_addr",  imem_addr, 32'h8);
            chk("wait_valid", {31'b0, if_ex_valid}, 32'd0);
        end
        step(); imem_ready = 1'b1; sample();                // c12
        chk("c12_addr",  imem_addr, 32'h8);
        chk("c12_valid", {31'b0, if_ex_valid}, 32'd0);
        push(32'h8);

        step(); branch_taken = 1'b1; branch_target = 32'h42; sample(); // c13
        chk("c13_addr", imem_addr, 32'hC);
        step(); branch_taken = 1'b0; sample();              // c14
        chk("c14_trap",  {31'b0, misaligned_trap}, {31'b0, redir_trap});
        chk("c14_addr",  imem_addr, redir_pc);
        chk("c14_valid", {31'b0, if_ex_valid}, 32'd0);
        push(redir_pc);
        step(); branch_taken = 1'b1; branch_target = 32'h20; sample(); // c15
        chk("c15_trap", {31'b0, misaligned_trap}, 32'd0);
        chk("c15_addr", imem_addr, redir_pc + 32'd4);

        step(); branch_taken = 1'b0; imem_ready = 1'b0; sample(); // c16
        chk("c16_addr", imem_addr, 32'h20);
        step(); rst = 1'b1; sample();                       // c17: WAIT at 0x20
        chk("c17_req",  {31'b0, imem_req}, 32'd1);
        chk("c17_addr", imem_addr, 32'h20);
        step(); rst = 1'b0; imem_ready = 1'b1; sample();    // c18
        chk("c18_req",   {31'b0, imem_req}, 32'd0);
        chk("c18_addr",  imem_addr, 32'h0);
        chk("c18_valid", {31'b0, if_ex_valid}, 32'd0);
        step(); sample();                                   // c19
        chk("c19_addr", imem_addr, 32'h0); push(32'h0);
        step(); sample();                                   // c20
        chk("c20_addr", imem_addr, 32'h4); push(32'h4);

        step(); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; sample(); // c21
        chk("c21_addr", imem_addr, 32'h8);
        step(); branch_taken = 1'b0; sample();              // c22
        chk("c22_addr", imem_addr, 32'hFFFF_FFFC); push(32'hFFFF_FFFC);
        step(); stall = 1'b1; sample();                     // c23: PC wrapped
        chk("c23_addr", imem_addr, 32'h0);
        step(); sample();                                   // c24
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
